// File: rtl/chunked_addsub_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared CHUNK-bit ripple adder.
// Reports unsigned carry/borrow and signed overflow once all chunks are done.
module parametric_RCA #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);
  logic [SIZE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SIZE];
endmodule

module chunked_addsub_ctrl #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] opa, opb, work, work_n;
  logic [CHUNK-1:0] asum;
  logic             acout;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             cin_msb;

  parametric_RCA #(.SIZE(CHUNK)) u_rca (
    .a    (opa[CHUNK-1:0]),
    .b    (opb[CHUNK-1:0]),
    .cin  (carry),
    .sum  (asum),
    .cout (acout)
  );

  assign last    = (cnt == CW'(N - 1));
  assign accept  = start && (state == IDLE || state == DONE);
  assign cin_msb = opa[CHUNK-1] ^ opb[CHUNK-1] ^ asum[CHUNK-1];
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  // Sum chunks enter at the top so the final chunk lands in the MSBs.
  always_comb begin
    work_n = work >> CHUNK;
    work_n[WIDTH-1 -: CHUNK] = asum;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      work  <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> CHUNK;
      opb   <= opb >> CHUNK;
      work  <= work_n;
      carry <= acout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        result <= work_n;
        cout   <= acout;
        ovf    <= cin_msb ^ acout;
      end
    end
  end
endmodule

// File: tb/tb_chunked_addsub_ctrl.sv
// Self-checking bench for chunked_addsub_ctrl at default parameters.
// Table vectors, handshake corners and a reference-model scoreboard.
module tb_chunked_addsub_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    string       name;
    logic        s;
    logic [15:0] x;
    logic [15:0] y;
    res_t        e;
  } vec_t;

  res_t q[$];
  vec_t tbl[5];

  chunked_addsub_ctrl #(.WIDTH(16), .CHUNK(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic s, input logic [15:0] x,
                                 input logic [15:0] y);
    res_t        m;
    logic [16:0] t;
    if (!s) begin
      t   = {1'b0, x} + {1'b0, y};
      m.r = t[15:0];
      m.c = t[16];
      m.o = (x[15] == y[15]) && (m.r[15] != x[15]);
    end else begin
      m.r = x - y;
      m.c = (x >= y);
      m.o = (x[15] != y[15]) && (m.r[15] != x[15]);
    end
    return m;
  endfunction

  task automatic fire(input logic s, input logic [15:0] x,
                      input logic [15:0] y, input res_t e);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    q.push_back(e);
  endtask

  task automatic issue(input logic s, input logic [15:0] x,
                       input logic [15:0] y, input res_t e);
    @(negedge clk);
    fire(s, x, y, e);
  endtask

  // Waits for done; lat counts cycles from the start edge.
  task automatic collect(input string nm, input bit mid,
                         output int lat, output int bcnt);
    res_t e;
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid && i == 2) begin
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        chk({nm, " busy_with_done"}, {31'd0, busy}, 32'd0);
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s: done with empty scoreboard", nm);
        end else begin
          e = q.pop_front();
          chk({nm, " result"}, {16'd0, result}, {16'd0, e.r});
          chk({nm, " cout"}, {31'd0, cout}, {31'd0, e.c});
          chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, e.o});
        end
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for done got 0 expected 1", nm);
    end
  endtask

  task automatic chk_timing(input string nm, input int lat, input int bcnt);
    chk({nm, " latency"}, lat, N + 1);
    chk({nm, " busy_cycles"}, bcnt, N);
  endtask

  initial begin
    int   lat, bcnt, ndone;
    res_t e;
    logic [15:0] x, y;
    logic        s;

    tbl[0] = '{"add",      1'b0, 16'h1234, 16'h0FFF, '{16'h2233, 1'b0, 1'b0}};
    tbl[1] = '{"wrap",     1'b0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0}};
    tbl[2] = '{"sovf",     1'b0, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b1}};
    tbl[3] = '{"sub_brw",  1'b1, 16'h0005, 16'h0007, '{16'hFFFE, 1'b0, 1'b0}};
    tbl[4] = '{"sub_ovf",  1'b1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b1, 1'b1}};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", {16'd0, result}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].e);
      collect(tbl[i].name, 1'b0, lat, bcnt);
      chk_timing(tbl[i].name, lat, bcnt);
      @(negedge clk);
      chk({tbl[i].name, " done_pulse"}, {31'd0, done}, 32'd0);
    end

    // Start pulsed mid-RUN must be ignored.
    issue(1'b0, 16'h1111, 16'h2222, '{16'h3333, 1'b0, 1'b0});
    collect("ignore", 1'b1, lat, bcnt);
    chk_timing("ignore", lat, bcnt);
    @(negedge clk);
    chk("ignore no_rerun", {31'd0, busy}, 32'd0);

    // Back-to-back: next start issued in the DONE cycle.
    issue(1'b0, 16'h0100, 16'h0200, '{16'h0300, 1'b0, 1'b0});
    collect("b2b0", 1'b0, lat, bcnt);
    fire(1'b1, 16'h0300, 16'h0100, '{16'h0200, 1'b1, 1'b0});
    collect("b2b1", 1'b0, lat, bcnt);
    chk_timing("b2b1", lat, bcnt);
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = 16'($urandom);
      fire(s, x, y, model(s, x, y));
      collect("rand", 1'b0, lat, bcnt);
      chk_timing("rand", lat, bcnt);
    end

    // Nonzero outputs before the abort so the reset zeroing is visible.
    issue(1'b1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b1, 1'b1});
    collect("pre_abort", 1'b0, lat, bcnt);
    issue(1'b0, 16'h5555, 16'h1111, '{16'h6666, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", {16'd0, result}, 32'd0);
    chk("abort cout", {31'd0, cout}, 32'd0);
    chk("abort ovf", {31'd0, ovf}, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort no_done", ndone, 0);

    issue(1'b0, 16'h0001, 16'h0001, '{16'h0002, 1'b0, 1'b0});
    collect("post_abort", 1'b0, lat, bcnt);
    chk_timing("post_abort", lat, bcnt);
    chk("scoreboard empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
